median_window_gen: RTL
======================

# median_window_gen

Streaming 3x3 window generator feeding the median filter datapath. It sits downstream of the configuration memory, taking `en`, `iw` and `ih` from it. It accepts raster-order pixels over a valid/ready stream, buffers two image lines, and emits one 9-pixel window for every input pixel whose row and column are both >= 2. Windows cover only the image interior, so a frame produces (iw-2)*(ih-2) windows.

## Interface
Parameters:
- `DW`, 8, pixel width in bits
- `MAX_W`, 1024, maximum supported image width (line buffer depth)
- `AW`, 10, column address width; must satisfy 2^AW >= MAX_W

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rstb`  in  1  asynchronous, active-low reset; connected to the configuration block's `rstb_int`
- `en`  in  1  filter enable from configuration register 0 bit 0
- `iw`  in  16  image width in pixels
- `ih`  in  16  image height in lines
- `s_valid`  in  1  input pixel valid
- `s_ready`  out  1  input pixel accepted when `s_valid && s_ready`
- `s_data`  in  DW  input pixel, raster order
- `m_valid`  out  1  output window valid
- `m_ready`  in  1  downstream ready
- `m_win`  out  9*DW  window; tap (r,c) at `m_win[DW*(3*r+c) +: DW]`, r=0 is the oldest line, c=0 is the oldest column, tap (2,2) is the newest pixel
- `m_sof`  out  1  first window of the frame
- `m_eol`  out  1  last window of a line (column iw-1)
- `m_eof`  out  1  last window of the frame
- `err`  out  1  sticky: the latched geometry was out of range

## Operation
- State machine:
  - IDLE:
    - `s_ready`=0.
    - When `en`=1, latch `iw`/`ih` into internal registers.
    - If 3<=iw<=MAX_W and 3<=ih, go to RUN with col=0, row=0.
    - Otherwise set `err`=1 and stay in IDLE.
  - RUN:
    - Consume pixels.
    - After the pixel at (ih-1, iw-1) is accepted, go to IDLE. The next frame re-samples `en`/`iw`/`ih`.
- `en` or `iw`/`ih` changes during RUN have no effect until the frame boundary.
- `err` clears only on reset.
- Counters:
  - col increments per accepted pixel and wraps to 0 after iw-1, at which point row increments.
  - Arithmetic uses unsigned 16-bit compares against the latched values.
- Line buffers:
  - Two arrays of MAX_W x DW: L1 holds the previous line and L0 holds the line before it.
  - Both are read combinationally at address col.
  - On an accepted pixel: L0[col] <= L1[col], and L1[col] <= s_data.
  - Line buffers are not reset; their contents in rows 0-1 are don't-care because no window is emitted there.
- Window shift:
  - On each accepted pixel, each window row shifts left by one column.
  - The new column is {L0[col], L1[col], s_data} for rows 0, 1, 2.
- Output:
  - If the accepted pixel has row>=2 and col>=2, load the output register and set `m_valid`=1.
  - `m_sof` = (row==2 && col==2).
  - `m_eol` = (col==iw-1).
  - `m_eof` = `m_eol` && (row==ih-1).
  - Flags are qualified by `m_valid`.
- Backpressure: `s_ready` = RUN && (!`m_valid` || `m_ready`). No pixel is accepted while an undelivered window is held.

## Timing
- Reset values:
  - state IDLE; `s_ready`, `m_valid`, `m_sof`, `m_eol` and `m_eof` are 0.
  - `m_win` = 0; `err` = 0; col and row are 0.
- Latency: a window whose newest pixel is accepted at edge N is visible with `m_valid`=1 after edge N; that is, 1 cycle.
- Holding rules:
  - `m_valid`, `m_win` and the flags hold stable until `m_valid && m_ready`.
  - On that edge, `m_valid` drops unless a new qualifying pixel is accepted on the same edge. That simultaneous case sustains full throughput of 1 window per cycle.
- IDLE to RUN takes 1 cycle after `en` is sampled high. `s_ready` rises in the cycle after the transition edge.
- Reset asserted mid-frame:
  - All state returns to reset values immediately and asynchronously.
  - The partial frame is discarded; the next frame starts at (0,0).
- Column wrap and line-buffer write happen on the same edge; there is no bubble between lines or between frames, apart from the single IDLE cycle.

## Test plan
- Frame with iw=5, ih=4, en=1, s_data=row*16+col, `m_ready`=1:
  - 6 windows are produced.
  - The first window (`m_sof`) is {0,1,2,16,17,18,32,33,34} for taps (0,0) to (2,2).
  - The last window has `m_eof` and tap (2,2)=0x34.
- Backpressure: hold `m_ready`=0 for 5 cycles mid-frame.
  - `s_ready`=0 throughout and `m_win` stays stable.
  - On release the window sequence matches the unstalled run exactly.
- Geometry error:
  - iw=2, en=1 -> `err`=1 and `s_ready` stays 0.
  - iw=MAX_W+1 -> same.
  - Reset clears `err`.
- Changing iw from 640 to 320 mid-frame does not affect the current frame (638*478 windows). The next frame uses 320.
- Reset pulse after 100 pixels of a 640x480 frame:
  - All outputs are 0 immediately.
  - A fresh frame yields a correct `m_sof` window at its pixel (2,2).
- Back-to-back frames of 3x3: exactly 1 window each, with `m_sof`, `m_eol` and `m_eof` all set. The second frame's window uses no data from the first.

Source files
------------

// File: rtl/median_window_gen.sv
// Streaming 3x3 window generator: buffers two image lines and emits one window
// per interior pixel of a raster-order frame, with sof/eol/eof markers.
module median_window_gen #(
  parameter int DW    = 8,
  parameter int MAX_W = 1024,
  parameter int AW    = 10
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            en,
  input  logic [15:0]     iw,
  input  logic [15:0]     ih,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [9*DW-1:0] m_win,
  output logic            m_sof,
  output logic            m_eol,
  output logic            m_eof,
  output logic            err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [15:0]     iw_q, iw_d, ih_q, ih_d;
  logic [15:0]     col_q, col_d, row_q, row_d;
  logic            err_q, err_d;
  logic [9*DW-1:0] sh_q, sh_d, sh_nx, win_q, win_d;
  logic            vld_q, vld_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
  logic [DW-1:0]   l0_mem [MAX_W];
  logic [DW-1:0]   l1_mem [MAX_W];
  logic [DW-1:0]   l0_rd, l1_rd;
  logic [AW-1:0]   addr;
  logic            rdy, acc, last_col, last_row;

  assign addr     = col_q[AW-1:0];
  assign l0_rd    = l0_mem[addr];
  assign l1_rd    = l1_mem[addr];
  assign rdy      = (state_q == RUN) && (!vld_q || m_ready);
  assign acc      = s_valid && rdy;
  assign last_col = (col_q == iw_q - 16'd1);
  assign last_row = (row_q == ih_q - 16'd1);

  always_comb begin
    state_d = state_q;
    iw_d    = iw_q;
    ih_d    = ih_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;
    win_d   = win_q;
    vld_d   = vld_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    // Each row shifts toward column 0; the fresh column enters at column 2.
    sh_nx   = '0;
    for (int r = 0; r < 3; r++) begin
      sh_nx[DW*(3*r)   +: DW] = sh_q[DW*(3*r+1) +: DW];
      sh_nx[DW*(3*r+1) +: DW] = sh_q[DW*(3*r+2) +: DW];
    end
    sh_nx[DW*2 +: DW] = l0_rd;
    sh_nx[DW*5 +: DW] = l1_rd;
    sh_nx[DW*8 +: DW] = s_data;
    sh_d = acc ? sh_nx : sh_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          iw_d = iw;
          ih_d = ih;
          if (iw >= 16'd3 && iw <= 16'(MAX_W) && ih >= 16'd3) begin
            state_d = RUN;
            col_d   = '0;
            row_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (acc) begin
          col_d = last_col ? 16'd0 : col_q + 16'd1;
          if (last_col) row_d = row_q + 16'd1;
          if (last_col && last_row) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new window may replace the one being consumed on the same edge.
    if (acc && row_q >= 16'd2 && col_q >= 16'd2) begin
      vld_d = 1'b1;
      win_d = sh_nx;
      sof_d = (row_q == 16'd2) && (col_q == 16'd2);
      eol_d = last_col;
      eof_d = last_col && last_row;
    end else if (m_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      iw_q    <= '0;
      ih_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
      sh_q    <= '0;
      win_q   <= '0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iw_q    <= iw_d;
      ih_q    <= ih_d;
      col_q   <= col_d;
      row_q   <= row_d;
      err_q   <= err_d;
      sh_q    <= sh_d;
      win_q   <= win_d;
      vld_q   <= vld_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
    end
  end

  // Line buffers carry no reset; rows 0-1 never produce a window.
  always_ff @(posedge clk) begin
    if (acc) begin
      l0_mem[addr] <= l1_rd;
      l1_mem[addr] <= s_data;
    end
  end

  assign s_ready = rdy;
  assign m_valid = vld_q;
  assign m_win   = win_q;
  assign m_sof   = vld_q & sof_q;
  assign m_eol   = vld_q & eol_q;
  assign m_eof   = vld_q & eof_q;
  assign err     = err_q;

endmodule
